// File: rtl/sram_sp_bwm.sv
// sram_sp_bwm: single-port synchronous SRAM behavioural model with per-bit
// write mask, 1- or 2-cycle read latency and a self-clearing init sweep.
// Ports:
//   CLK    in   clock, rising edge
//   RSTB   in   asynchronous active-low reset
//   CEB    in   chip enable, active-low
//   WEB    in   0 = write, 1 = read (when CEB=0)
//   BWEB   in   per-bit write enable, active-low
//   A      in   word address
//   D      in   write data
//   Q      out  registered read data
//   READY  out  high once the init sweep has cleared every word
module sram_sp_bwm #(
  parameter int unsigned Bits         = 16,
  parameter int unsigned Word_Depth   = 256,
  parameter int unsigned Add_Width    = 8,
  parameter int unsigned Read_Latency = 1,
  parameter int unsigned Hold_Output  = 1
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 CEB,
  input  logic                 WEB,
  input  logic [Bits-1:0]      BWEB,
  input  logic [Add_Width-1:0] A,
  input  logic [Bits-1:0]      D,
  output logic [Bits-1:0]      Q,
  output logic                 READY
);

  localparam int unsigned IdxW  = (Word_Depth > 1) ? $clog2(Word_Depth) : 1;
  localparam int unsigned AW1   = Add_Width + 1;
  localparam bit          HoldQ = (Hold_Output != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 r_state;
  logic [Add_Width-1:0]   r_cnt;
  logic                   r_ready;
  logic [Bits-1:0]        r_q;
  logic [Bits-1:0]        r_mem [Word_Depth];

  logic                   w_run;
  logic                   w_in_range;
  logic                   w_rd;
  logic                   w_wr_acc;
  logic [Bits-1:0]        w_rdata;
  logic                   w_we;
  logic [IdxW-1:0]        w_widx;
  logic [Bits-1:0]        w_wdata;
  logic [Bits-1:0]        w_wbweb;

  // Zero-extend both sides so Word_Depth == 2^Add_Width does not overflow.
  assign w_in_range = ({1'b0, A} < AW1'(Word_Depth));
  assign w_run      = (r_state == ST_RUN);
  assign w_rd       = w_run & ~CEB & WEB;
  assign w_wr_acc   = w_run & ~CEB & ~WEB & w_in_range;
  assign w_rdata    = w_in_range ? r_mem[A[IdxW-1:0]] : '0;

  // Array write port: the init sweep owns it until READY, then the user does.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = A[IdxW-1:0];
    w_wdata = D;
    w_wbweb = BWEB;
    if (!w_run) begin
      w_we    = 1'b1;
      w_widx  = r_cnt[IdxW-1:0];
      w_wdata = '0;
      w_wbweb = '0;
    end else if (w_wr_acc) begin
      w_we = 1'b1;
    end
  end

  // Storage array, intentionally without reset; the sweep clears it.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_widx] <= (r_mem[w_widx] & w_wbweb) | (w_wdata & ~w_wbweb);
    end
  end

  // INIT/RUN sequencer.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + Add_Width'(1);
      if (r_cnt == Add_Width'(Word_Depth - 1)) begin
        r_state <= ST_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  generate
    if (Read_Latency == 2) begin : g_lat2
      logic [Bits-1:0] r_stage;
      logic            r_stage_vld;

      // Stage register carries the read and whether this slot was a read,
      // so non-read cycles reach Q with the same two-edge timing.
      always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
          r_stage     <= '0;
          r_stage_vld <= 1'b0;
          r_q         <= '0;
        end else begin
          r_stage_vld <= w_rd;
          if (w_rd) begin
            r_stage <= w_rdata;
          end
          if (r_stage_vld) begin
            r_q <= r_stage;
          end else if (!HoldQ) begin
            r_q <= '0;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
          r_q <= '0;
        end else if (w_rd) begin
          r_q <= w_rdata;
        end else if (!HoldQ) begin
          r_q <= '0;
        end
      end
    end
  endgenerate

  assign Q     = r_q;
  assign READY = r_ready;

endmodule

// File: tb/tb_sram_sp_bwm.sv
// Bench for sram_sp_bwm: five configurations share one stimulus stream
// (256-deep in all latency/hold combinations, plus a 200-deep instance).
// Expected Q per instance is pushed to a scoreboard queue as each access is
// driven and popped after the edge at which that instance updates Q.
module tb_sram_sp_bwm;

  localparam int N = 5;
  typedef logic [N-1:0][15:0] qvec_t;

  logic        clk;
  logic        rstb;
  logic        ceb;
  logic        web;
  logic [15:0] bweb;
  logic [7:0]  a;
  logic [15:0] d;
  qvec_t       qv;
  logic [N-1:0] rdv;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl [256];
  qvec_t       sb [$];
  qvec_t       pend;
  qvec_t       lastv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_sp_bwm #(.Bits(16), .Word_Depth(256), .Add_Width(8), .Read_Latency(1), .Hold_Output(1)) u_l1h1 (
    .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(qv[0]), .READY(rdv[0]));
  sram_sp_bwm #(.Bits(16), .Word_Depth(256), .Add_Width(8), .Read_Latency(2), .Hold_Output(1)) u_l2h1 (
    .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(qv[1]), .READY(rdv[1]));
  sram_sp_bwm #(.Bits(16), .Word_Depth(256), .Add_Width(8), .Read_Latency(1), .Hold_Output(0)) u_l1h0 (
    .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(qv[2]), .READY(rdv[2]));
  sram_sp_bwm #(.Bits(16), .Word_Depth(256), .Add_Width(8), .Read_Latency(2), .Hold_Output(0)) u_l2h0 (
    .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(qv[3]), .READY(rdv[3]));
  sram_sp_bwm #(.Bits(16), .Word_Depth(200), .Add_Width(8), .Read_Latency(1), .Hold_Output(1)) u_d200 (
    .CLK(clk), .RSTB(rstb), .CEB(ceb), .WEB(web), .BWEB(bweb), .A(a), .D(d), .Q(qv[4]), .READY(rdv[4]));

  function automatic int lat_of(input int k);
    return (k == 1 || k == 3) ? 2 : 1;
  endfunction

  function automatic bit hold_of(input int k);
    return !(k == 2 || k == 3);
  endfunction

  function automatic int depth_of(input int k);
    return (k == 4) ? 200 : 256;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
    sb.delete();
    pend  = '0;
    lastv = '0;
  endtask

  // Init sweep after RSTB release; a write to A=5 is attempted while every
  // instance is still in INIT and must be ignored.
  task automatic sweep(input string tag);
    for (int e = 1; e <= 256; e++) begin
      if (e <= 200) begin
        ceb = 1'b0; web = 1'b0; a = 8'd5; d = 16'hFFFF; bweb = 16'h0000;
      end else begin
        ceb = 1'b1; web = 1'b1; a = 8'd0; d = 16'h0000; bweb = 16'hFFFF;
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        logic exp_r;
        exp_r = (e >= depth_of(k));
        chk($sformatf("%s_ready%0d_e%0d", tag, k, e), {15'd0, rdv[k]}, {15'd0, exp_r});
        chk($sformatf("%s_q%0d_e%0d", tag, k, e), qv[k], 16'h0000);
      end
    end
    reset_model();
  endtask

  // One access cycle: predict each instance's Q, drive, clock, compare.
  task automatic step(input logic c, input logic w, input logic [7:0] aa,
                      input logic [15:0] dd, input logic [15:0] bb);
    qvec_t       e;
    logic [15:0] rd;
    logic [15:0] nv;
    ceb = c; web = w; a = aa; d = dd; bweb = bb;
    for (int k = 0; k < N; k++) begin
      rd = (int'(aa) >= depth_of(k)) ? 16'h0000 : mdl[aa];
      nv = (!c && w) ? rd : (hold_of(k) ? lastv[k] : 16'h0000);
      lastv[k] = nv;
      if (lat_of(k) == 2) begin
        e[k]    = pend[k];
        pend[k] = nv;
      end else begin
        e[k] = nv;
      end
    end
    sb.push_back(e);
    if (!c && !w) mdl[aa] = (mdl[aa] & bb) | (dd & ~bb);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      for (int k = 0; k < N; k++) begin
        chk($sformatf("q%0d_a%0h", k, aa), qv[k], e[k]);
        chk($sformatf("ready%0d", k), {15'd0, rdv[k]}, 16'h0001);
      end
    end
  endtask

  task automatic rd(input logic [7:0] aa);
    step(1'b0, 1'b1, aa, 16'h0000, 16'hFFFF);
  endtask

  task automatic wr(input logic [7:0] aa, input logic [15:0] dd, input logic [15:0] bb);
    step(1'b0, 1'b0, aa, dd, bb);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 8'd0, 16'h0000, 16'hFFFF);
  endtask

  initial begin
    rstb = 1'b0; ceb = 1'b1; web = 1'b1; a = 8'd0; d = 16'h0000; bweb = 16'hFFFF;
    reset_model();
    #12;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_q%0d", k), qv[k], 16'h0000);
      chk($sformatf("rst_ready%0d", k), {15'd0, rdv[k]}, 16'h0000);
    end
    @(negedge clk);
    rstb = 1'b1;
    sweep("init");

    // Cleared words and the ignored INIT write.
    rd(8'd0); rd(8'd128); rd(8'd255); rd(8'd5);
    chk("init_write_ignored", qv[0], 16'h0000);

    // Bit mask, then read right after the write.
    wr(8'd3, 16'hFFFF, 16'h0000);
    wr(8'd3, 16'h0000, 16'hFF00);
    rd(8'd3);
    chk("mask_l1", qv[0], 16'hFF00);
    chk("mask_l1h0", qv[2], 16'hFF00);

    // Back-to-back streaming reads.
    wr(8'd1, 16'h1111, 16'h0000);
    wr(8'd2, 16'h2222, 16'h0000);
    wr(8'd3, 16'h3333, 16'h0000);
    rd(8'd1);
    chk("lat1_r1", qv[0], 16'h1111);
    rd(8'd2);
    chk("lat2_r1", qv[1], 16'h1111);
    rd(8'd3);
    chk("lat2_r2", qv[1], 16'h2222);
    idle();
    chk("lat2_r3", qv[1], 16'h3333);

    // Output hold versus zero on deselected cycles.
    rd(8'd1);
    idle(); idle(); idle();
    chk("hold_l1", qv[0], 16'h1111);
    chk("hold_l2", qv[1], 16'h1111);
    chk("zero_l1", qv[2], 16'h0000);
    chk("zero_l2", qv[3], 16'h0000);

    // Non-power-of-two depth.
    wr(8'd250, 16'hABCD, 16'h0000);
    rd(8'd250);
    chk("oor_d200", qv[4], 16'h0000);
    chk("inr_d256", qv[0], 16'hABCD);
    wr(8'd199, 16'h5A5A, 16'h0000);
    rd(8'd199);
    chk("last_d200", qv[4], 16'h5A5A);

    // Mixed traffic.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom));
    end
    idle(); idle();

    // Asynchronous reset with a latency-2 read in flight.
    wr(8'd1, 16'h7777, 16'h0000);
    rd(8'd1);
    #2 rstb = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("midrst_q%0d", k), qv[k], 16'h0000);
      chk($sformatf("midrst_ready%0d", k), {15'd0, rdv[k]}, 16'h0000);
    end
    @(negedge clk);
    rstb = 1'b1;
    sweep("reinit");
    rd(8'd1);
    chk("reinit_cleared", qv[0], 16'h0000);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
